// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one synchronous single-port RAM between the fetch and
//               load/store requesters. At most one access is issued per cycle.
//               Data accesses win, but a starvation counter forces a fetch
//               grant after STARVE_LIMIT consecutive data grants. Read data is
//               steered back to its owner one cycle after the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 31,
  parameter int DATA_WIDTH   = 31,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // Fetch requester
  input  logic                  i_f_req,
  input  logic [ADDR_WIDTH:0]   i_f_addr,
  output logic                  o_f_gnt,
  output logic                  o_f_rvalid,
  output logic [DATA_WIDTH:0]   o_f_rdata,
  // Data requester
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [3:0]            i_d_be,
  input  logic [ADDR_WIDTH:0]   i_d_addr,
  input  logic [DATA_WIDTH:0]   i_d_wdata,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [DATA_WIDTH:0]   o_d_rdata,
  // RAM port
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_be,
  output logic [ADDR_WIDTH:0]   o_mem_addr,
  output logic [DATA_WIDTH:0]   o_mem_wdata,
  input  logic [DATA_WIDTH:0]   i_mem_rdata,
  // Status
  output logic                  o_busy
);

  // State names the access issued in the previous cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    F_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       f_rvalid_q, f_rvalid_d;
  logic       d_rvalid_q, d_rvalid_d;
  logic       f_gnt, d_gnt;

  // Arbitration, starvation counter update and next-state decode.
  always_comb begin
    f_gnt        = 1'b0;
    d_gnt        = 1'b0;
    starve_cnt_d = starve_cnt_q;
    state_d      = IDLE;

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    if (rst) begin
      if (i_d_req && i_f_req) begin
        if (starve_cnt_q == STARVE_MAX) begin
          f_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
        end
      end else if (i_d_req) begin
        d_gnt = 1'b1;
      end else if (i_f_req) begin
        f_gnt = 1'b1;
      end
    end

    // Counter only tracks data grants that overtook a waiting fetch.
    if (!i_f_req || f_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (d_gnt && (starve_cnt_q < STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    if (f_gnt) begin
      state_d = F_RD;
    end else if (d_gnt) begin
      state_d = i_d_we ? D_WR : D_RD;
    end

    f_rvalid_d = (state_d == F_RD);
    d_rvalid_d = (state_d == D_RD);
  end

  // RAM port mux: driven from whichever requester won, all zero otherwise.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = 4'b0000;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (f_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_be   = 4'b1111;
      o_mem_addr = i_f_addr;
    end else if (d_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_d_addr;
      if (i_d_we) begin
        o_mem_we    = 1'b1;
        o_mem_be    = i_d_be;
        o_mem_wdata = i_d_wdata;
      end else begin
        o_mem_be    = 4'b1111;
      end
    end
  end

  // State, counter and response-valid registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      f_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      f_rvalid_q   <= f_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
    end
  end

  assign o_f_gnt    = f_gnt;
  assign o_d_gnt    = d_gnt;
  assign o_f_rvalid = f_rvalid_q;
  assign o_d_rvalid = d_rvalid_q;
  // Read data is only passed through to the owner of the outstanding read.
  assign o_f_rdata  = f_rvalid_q ? i_mem_rdata : '0;
  assign o_d_rdata  = d_rvalid_q ? i_mem_rdata : '0;
  assign o_busy     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter placed between the core and a synchronous single-port RAM. It shares the one RAM port between the instruction-fetch requester and the load/store data requester. Each cycle it issues at most one access, and routes read data back to its owner one cycle later. Data accesses have priority, and a starvation counter guarantees fetch progress.

## Interface
Parameters:
- ADDR_WIDTH, 31, MSB index of word addresses (address buses are ADDR_WIDTH+1 bits)
- DATA_WIDTH, 31, MSB index of data buses (data buses are DATA_WIDTH+1 bits; byte enables are fixed at 4 bits)
- STARVE_LIMIT, 4, number of consecutive data grants that a waiting fetch tolerates; range 1..15

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-low (low = reset)
- i_f_req  in  1  fetch read request; held with i_f_addr until o_f_gnt
- i_f_addr  in  ADDR_WIDTH+1  fetch word address
- o_f_gnt  out  1  fetch access issued this cycle (combinational)
- o_f_rvalid  out  1  o_f_rdata valid (registered)
- o_f_rdata  out  DATA_WIDTH+1  fetched word
- i_d_req  in  1  data request; held with all i_d_* inputs until o_d_gnt
- i_d_we  in  1  1 = write, 0 = read
- i_d_be  in  4  write byte enables
- i_d_addr  in  ADDR_WIDTH+1  data word address
- i_d_wdata  in  DATA_WIDTH+1  write data
- o_d_gnt  out  1  data access issued this cycle (combinational)
- o_d_rvalid  out  1  o_d_rdata valid (registered); never asserted for writes
- o_d_rdata  out  DATA_WIDTH+1  loaded word
- o_mem_en  out  1  RAM access this cycle
- o_mem_we  out  1  RAM write
- o_mem_be  out  4  RAM byte enables
- o_mem_addr  out  ADDR_WIDTH+1  RAM word address
- o_mem_wdata  out  DATA_WIDTH+1  RAM write data
- i_mem_rdata  in  DATA_WIDTH+1  RAM read data; valid the cycle after a read is issued
- o_busy  out  1  the previous cycle issued a RAM access (state != IDLE)

## Operation
- **Grant rule (combinational from requests and the counter):**
  - If only i_d_req is high: grant data.
  - If only i_f_req is high: grant fetch.
  - If both are high: grant data, unless starve_cnt == STARVE_LIMIT; then grant fetch.
  - If neither is high: no grant.
- **Issue:** o_mem_en = o_f_gnt | o_d_gnt. The RAM signals are driven from the granted requester.
  - Fetch grant: we = 0, be = 4'b1111, wdata = 0.
  - Data read: we = 0, be = 4'b1111.
  - Data write: we = 1, be = i_d_be, wdata = i_d_wdata.
  - When there is no grant, all o_mem_* are 0.
- **starve_cnt (4-bit register):**
  - Increments on a data grant while i_f_req is high.
  - Clears on a fetch grant or in any cycle with i_f_req low.
  - Otherwise it holds.
  - It never exceeds STARVE_LIMIT.
- **FSM:** the state records the access issued in the previous cycle.
  - States: IDLE, F_RD, D_RD, D_WR.
  - Next state each cycle is: F_RD on a fetch grant; D_RD on a data read grant; D_WR on a data write grant; else IDLE.
  - Any state can go to any state; back-to-back grants are allowed every cycle.
- **Response routing:**
  - o_f_rvalid is registered: high in the cycle after a fetch grant. o_d_rvalid likewise: high in the cycle after a data read grant. (These equal state == F_RD / state == D_RD.)
  - In F_RD, o_f_rdata = i_mem_rdata. In D_RD, o_d_rdata = i_mem_rdata.
  - In all other cases both rdata outputs are 0; there is no stale data.
- A write with i_d_be == 0 is still granted and issued (o_mem_we = 1, be = 0). It is a RAM no-op but a legal handshake.

## Timing
- **Grant:** o_*_gnt is asserted in the same cycle as the request when that requester wins. The requester drops or changes its request on the following edge.
- **Read latency:** exactly 1 cycle from gnt to rvalid. At most one read is outstanding, and a new grant may issue in the same cycle as rvalid.
- **Write:** completes at the grant edge. D_WR produces no response.
- **Fetch worst-case wait** under continuous data traffic: STARVE_LIMIT + 1 cycles from request to grant.
- **Reset (rst low, asynchronous):**
  - State → IDLE, starve_cnt → 0, o_f_rvalid = o_d_rvalid = 0, o_busy = 0.
  - While in reset, o_f_gnt, o_d_gnt and o_mem_* are forced to 0 regardless of requests.
  - A read granted in the cycle before reset asserts gets no rvalid.
  - After rst is released, the first grant is possible on the first edge.

## Test plan
- **Fetch only:** i_f_req = 1, i_f_addr = 0x10, RAM[0x10] = 0xDEADBEEF → o_f_gnt = 1 the same cycle; next cycle o_f_rvalid = 1 and o_f_rdata = 0xDEADBEEF; o_d_rvalid stays 0.
- **Data write then read:** write addr 0x20, be 4'b0011, wdata 0x12345678 → o_mem_we = 1 and o_mem_be = 0011, with no rvalid. Then a read of 0x20 over a RAM preloaded with 0xAAAAAAAA → o_d_rdata = 0xAAAA5678 one cycle after the grant.
- **Priority and starvation, STARVE_LIMIT = 4, both requests held high:**
  - Data is granted for 4 cycles, then fetch for 1 cycle, then data again.
  - starve_cnt reads 1, 2, 3, 4, 0.
- **Back-to-back alternation:** fetch read, data read, fetch read on consecutive cycles → rvalids alternate f, d, f with the correct data and no bubble; o_busy stays high throughout.
- **Reset mid-read:** grant a data read, then assert rst low mid-cycle before the next edge → o_d_rvalid = 0 and state = IDLE. After release with i_f_req = 1, fetch is granted on the first cycle.
- **Idle:** no requests → o_mem_en = 0, all o_mem_* = 0, both rdata outputs 0, o_busy falls 1 cycle after the last grant.
